reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Sequential reader for the 32×32 register bank. On a start pulse it walks every register through a combinational read port and captures each value once. It then streams one text line per register ("xNN:HHHHHHHH") as ASCII characters over a valid/ready handshake. The stream feeds the VGA text renderer, which places each character at the given row/column. The block is the read-side counterpart of the register bank's write port and replaces the flat all-registers bus for on-screen display.

## Interface
- NUM_REGS, 32, number of registers dumped, starting from index 0; legal range 1..32.
- DATA_W, 32, register width; fixed at 32 because the hex field is 8 digits.

- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- reg_idx  output  5  read address presented to the register bank.
- reg_data  input  32  register-bank read data; combinational from reg_idx in the same cycle.
- char_valid  output  1  char_data, char_row and char_col are valid.
- char_ready  input  1  consumer accepts the character; transfer occurs when valid && ready at a clock edge.
- char_data  output  8  ASCII code of the current character.
- char_row  output  5  line number, equal to the register index being emitted.
- char_col  output  4  column within the line, 0..11.
- busy  output  1  high in LATCH and EMIT.
- done  output  1  one-cycle pulse after the last character of the dump.

## Operation
- FSM states: IDLE, LATCH, EMIT, DONE.
  - IDLE → LATCH on start. Sets reg_idx=0 and col=0.
  - LATCH → EMIT unconditionally. Captures reg_data into a 32-bit snapshot.
  - EMIT: on each handshake the column advances.
    - On the handshake at col=11 with reg_idx=NUM_REGS-1: go to DONE.
    - On the handshake at col=11 otherwise: reg_idx+1, col=0, go to LATCH.
  - DONE → IDLE unconditionally. done=1 only in DONE.
- Character map per column:
  - col 0: 'x' (0x78).
  - col 1: '0' + reg_idx/10.
  - col 2: '0' + reg_idx%10.
  - col 3: ':' (0x3A).
  - cols 4..11: snapshot nibbles, MSB first (col 4 = bits 31:28).
  - Nibble encoding: 0-9 → 0x30+n; A-F → 0x41+(n-10), uppercase.
- char_row = reg_idx and char_col = col whenever char_valid=1.
- The snapshot is taken once per register in LATCH. Changes on reg_data during EMIT do not affect the output.
- start is ignored in LATCH, EMIT and DONE; there is no queuing.
- Backpressure: while char_valid=1 and char_ready=0, char_data/row/col hold stable and char_valid stays high. Nothing is dropped or repeated.
- Asserting reset_n low at any time forces IDLE immediately, regardless of clk. The dump is abandoned, and the next start restarts at x00.
- Reset values: reg_idx=0, char_valid=0, char_data=0x00, char_row=0, char_col=0, busy=0, done=0, snapshot=0.

## Timing
- Start accepted at edge E0 → LATCH during cycle after E0 (busy=1, reg_idx=0).
- Snapshot captured at E1; char_valid=1 with col 0 from after E1.
- Each character needs at least 1 cycle; with char_ready held high, one character transfers per edge.
- Per register: 1 LATCH cycle + 12 EMIT cycles = 13 cycles minimum.
- Full dump with ready held high: NUM_REGS×13 cycles from E0 to the last handshake, then 1 DONE cycle. For NUM_REGS=32 that is 416 + 1 cycles.
- char_valid is 0 during LATCH, DONE and IDLE. There is a one-cycle valid gap between lines.
- A start pulse in the same cycle as DONE is ignored.

## Test plan
- Basic dump: reset, bank holds x5=0xDEADBEEF and xi=i otherwise; ready=1; pulse start.
  - Exactly 384 characters transfer.
  - Row 5 reads "x05:DEADBEEF"; row 31 reads "x31:0000001F".
  - done pulses exactly once, in cycle 417 after start.
- Backpressure: ready driven low for 10 cycles mid-line, then randomised 50%.
  - char_data/row/col stay stable while stalled.
  - The character sequence is identical to the basic dump.
- Snapshot: change reg_data for x3 from 0x12345678 to 0xFFFFFFFF during row 3 emission.
  - Row 3 reads "x03:12345678".
- Start while busy: pulse start at character 50 and again in the DONE cycle.
  - Neither pulse has any effect; a single done pulse; the total character count is unchanged.
- Async reset: drop reset_n mid-cycle during row 7 (between clock edges).
  - All outputs reach their reset values before the next edge.
  - After release, a new start begins at row 0 / col 0.
- Parameter NUM_REGS=1: exactly 12 characters "x00:" plus the value of x0.
  - done pulses in cycle 14 after start.

Source files
------------

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register bank one index at a time.
// Each value is snapshotted once, then streamed as the 12-character text line
// "xNN:HHHHHHHH" over a valid/ready character interface.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [4:0]        reg_idx,
  input  logic [DATA_W-1:0] reg_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [7:0]        char_data,
  output logic [4:0]        char_row,
  output logic [3:0]        char_col,
  output logic              busy,
  output logic              done
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [3:0] LAST_COL = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_EMIT, S_DONE} state_t;

  state_t            state_q;
  logic [4:0]        idx_q;
  logic [3:0]        col_q;
  logic [DATA_W-1:0] snap_q;
  logic              valid_q;
  logic [7:0]        data_q;
  logic              busy_q;
  logic              done_q;

  // One hex digit as uppercase ASCII: 0x41 + (n - 10) folds to 0x37 + n.
  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character shown at a column of the line for register idx holding snap.
  function automatic logic [7:0] char_at(input logic [3:0] col,
                                         input logic [4:0] idx,
                                         input logic [DATA_W-1:0] snap);
    logic [7:0] ch;
    ch = 8'h00;
    case (col)
      4'd0:    ch = 8'h78;                               // 'x'
      4'd1:    ch = 8'h30 + {3'b000, idx / 5'd10};       // tens digit
      4'd2:    ch = 8'h30 + {3'b000, idx % 5'd10};       // units digit
      4'd3:    ch = 8'h3A;                               // ':'
      default: ch = hex_ch(4'(snap >> {4'd11 - col, 2'b00})); // col 4 = MS nibble
    endcase
    return ch;
  endfunction

  // Dump sequencer: all outputs registered so the consumer sees clean timing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      snap_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LATCH;
            idx_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_LATCH: begin
          // Snapshot once so later bank writes cannot tear the line.
          snap_q  <= reg_data;
          state_q <= S_EMIT;
          col_q   <= '0;
          valid_q <= 1'b1;
          data_q  <= 8'h78;
        end
        S_EMIT: begin
          if (char_ready) begin
            if (col_q == LAST_COL) begin
              valid_q <= 1'b0;
              if (idx_q == LAST_IDX) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q   <= idx_q + 5'd1;
                col_q   <= '0;
                state_q <= S_LATCH;
              end
            end else begin
              col_q  <= col_q + 4'd1;
              data_q <= char_at(col_q + 4'd1, idx_q, snap_q);
            end
          end
        end
        S_DONE: begin
          // start is deliberately not looked at here: no queued dumps.
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          idx_q   <= '0;
          col_q   <= '0;
          data_q  <= 8'h00;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign reg_idx    = idx_q;
  assign char_valid = valid_q;
  assign char_data  = data_q;
  assign char_row   = idx_q;
  assign char_col   = col_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Testbench for reg_dump_reader: a bank model drives reg_data, a negedge
// collector records every handshake, and expected lines come from sformatf.
module tb_reg_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, char_ready;
  logic [4:0]  reg_idx, char_row;
  logic [31:0] reg_data;
  logic        char_valid, busy, done;
  logic [7:0]  char_data;
  logic [3:0]  char_col;
  logic [31:0] bank [32];

  logic        start1;
  logic [4:0]  reg_idx1, char_row1;
  logic [31:0] reg_data1, bank1_x0;
  logic        char_valid1, busy1, done1;
  logic [7:0]  char_data1;
  logic [3:0]  char_col1;

  assign reg_data  = bank[reg_idx];
  assign reg_data1 = (reg_idx1 == 5'd0) ? bank1_x0 : 32'hBAD0BAD0;

  reg_dump_reader #(.NUM_REGS(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .reg_idx(reg_idx),
    .reg_data(reg_data), .char_valid(char_valid), .char_ready(char_ready),
    .char_data(char_data), .char_row(char_row), .char_col(char_col),
    .busy(busy), .done(done));

  reg_dump_reader #(.NUM_REGS(1), .DATA_W(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .reg_idx(reg_idx1),
    .reg_data(reg_data1), .char_valid(char_valid1), .char_ready(1'b1),
    .char_data(char_data1), .char_row(char_row1), .char_col(char_col1),
    .busy(busy1), .done(done1));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0 = 0;
  int stall_err = 0;
  logic [16:0] got [$];
  logic [16:0] got1 [$];
  int done_cyc [$];
  int done_cyc1 [$];
  logic [16:0] prev = '0;
  bit prev_stall = 0;

  // Negedge collector: handshakes happen at the following posedge.
  always @(negedge clk) begin
    cyc++;
    if (reset_n && char_valid && char_ready) got.push_back({char_row, char_col, char_data});
    if (reset_n && char_valid1) got1.push_back({char_row1, char_col1, char_data1});
    if (done) done_cyc.push_back(cyc);
    if (done1) done_cyc1.push_back(cyc);
    if (prev_stall && reset_n && !(char_valid && {char_row, char_col, char_data} == prev))
      stall_err++;
    prev_stall = reset_n && char_valid && !char_ready;
    prev = {char_row, char_col, char_data};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  // Reference text for one register line.
  function automatic string line_of(input int i, input logic [31:0] v);
    string s, hexd;
    int nib;
    hexd = "0123456789ABCDEF";
    s = $sformatf("x%02d:", i);
    for (int k = 7; k >= 0; k--) begin
      nib = int'((v >> (4 * k)) & 32'hF);
      s = {s, hexd.substr(nib, nib)};
    end
    return s;
  endfunction

  function automatic string row_str(input logic [16:0] q [$], input int r);
    string s;
    s = "";
    foreach (q[i]) if (int'(q[i][16:12]) == r) s = $sformatf("%s%c", s, q[i][7:0]);
    return s;
  endfunction

  // Count of characters that differ from the full reference dump.
  function automatic int seq_mism(input logic [16:0] q [$], input logic [31:0] vals [32]);
    int m, r, c;
    string s;
    logic [16:0] e;
    m = 0;
    foreach (q[i]) begin
      r = i / 12;
      c = i % 12;
      s = line_of(r, vals[r % 32]);
      e = {r[4:0], c[3:0], s[c]};
      if (q[i] !== e) m++;
    end
    return m;
  endfunction

  // Start a dump and drive ready per mode until 20 cycles past done.
  // mode 0 plain, 1 backpressure, 2 snapshot overwrite, 3 start while busy.
  task automatic run_dump(input int mode, output bit timed_out);
    int stall_left, after;
    bit stalled_once, did50, seen_done;
    got.delete();
    done_cyc.delete();
    @(posedge clk); #1;
    start = 1'b1;
    c0 = cyc + 2;
    @(posedge clk); #1;
    start = 1'b0;
    stall_left = 0; after = 0;
    stalled_once = 0; did50 = 0; seen_done = 0; timed_out = 1;
    for (int n = 0; n < 4000; n++) begin
      start = 1'b0;
      char_ready = 1'b1;
      if (mode == 1) begin
        if (!stalled_once && got.size() >= 20) begin
          stalled_once = 1;
          stall_left = 10;
        end
        if (stall_left > 0) begin
          char_ready = 1'b0;
          stall_left--;
        end else if (stalled_once) begin
          char_ready = 1'($urandom_range(0, 1));
        end
      end
      if (mode == 2 && char_valid && char_row == 5'd3 && char_col == 4'd6)
        bank[3] = 32'hFFFFFFFF;
      if (mode == 3) begin
        if (!did50 && got.size() >= 50) begin
          did50 = 1;
          start = 1'b1;
        end
        if (done) start = 1'b1;
      end
      if (seen_done) begin
        after++;
        if (after >= 20) begin
          timed_out = 0;
          break;
        end
      end
      if (done) seen_done = 1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    char_ready = 1'b1;
  endtask

  logic [31:0] exp_vals [32];
  bit to;
  string s1;

  initial begin
    reset_n = 1'b0; start = 1'b0; start1 = 1'b0; char_ready = 1'b1;
    bank1_x0 = 32'h0;
    for (int i = 0; i < 32; i++) bank[i] = 32'(i);
    bank[5] = 32'hDEADBEEF;
    @(negedge clk);
    chk("reset_valid", {63'd0, char_valid}, 64'd0);
    chk("reset_outs", {29'd0, reg_idx, char_data, char_row, char_col, busy, done}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic dump
    exp_vals = bank;
    run_dump(0, to);
    chk("basic_timeout", {63'd0, to}, 64'd0);
    chk("basic_count", 64'(got.size()), 64'd384);
    chk("basic_seq", 64'(seq_mism(got, exp_vals)), 64'd0);
    chk_s("basic_row5", row_str(got, 5), "x05:DEADBEEF");
    chk_s("basic_row31", row_str(got, 31), "x31:0000001F");
    chk("basic_done_pulses", 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() > 0) chk("basic_done_cycle", 64'(done_cyc[0] - c0 + 1), 64'd417);

    // Backpressure
    stall_err = 0;
    run_dump(1, to);
    chk("bp_timeout", {63'd0, to}, 64'd0);
    chk("bp_count", 64'(got.size()), 64'd384);
    chk("bp_seq", 64'(seq_mism(got, exp_vals)), 64'd0);
    chk("bp_stall_stable", 64'(stall_err), 64'd0);
    chk("bp_done_pulses", 64'(done_cyc.size()), 64'd1);

    // Snapshot with randomized bank contents
    for (int i = 0; i < 32; i++) bank[i] = $urandom;
    bank[3] = 32'h12345678;
    exp_vals = bank;
    run_dump(2, to);
    chk("snap_timeout", {63'd0, to}, 64'd0);
    chk_s("snap_row3", row_str(got, 3), "x03:12345678");
    chk("snap_seq", 64'(seq_mism(got, exp_vals)), 64'd0);
    chk("snap_count", 64'(got.size()), 64'd384);

    // Start while busy and in DONE
    exp_vals = bank;
    run_dump(3, to);
    chk("sb_timeout", {63'd0, to}, 64'd0);
    chk("sb_count", 64'(got.size()), 64'd384);
    chk("sb_done_pulses", 64'(done_cyc.size()), 64'd1);
    chk("sb_idle_after", {62'd0, busy, char_valid}, 64'd0);
    chk("sb_seq", 64'(seq_mism(got, exp_vals)), 64'd0);

    // Async reset mid-cycle during row 7
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 300 && !(char_valid && char_row == 5'd7); n++) begin
      @(posedge clk); #1;
    end
    chk("ar_reach_row7", {58'd0, char_valid, char_row}, {58'd0, 1'b1, 5'd7});
    #2 reset_n = 1'b0;
    #1;
    chk("ar_outs", {29'd0, reg_idx, char_data, char_row, char_col, busy, done}, 64'd0);
    chk("ar_valid", {63'd0, char_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_dump(0, to);
    chk("ar_timeout", {63'd0, to}, 64'd0);
    chk("ar_first_char", (got.size() > 0) ? 64'(got[0]) : 64'h1FFFF, {47'd0, 5'd0, 4'd0, 8'h78});
    chk("ar_count", 64'(got.size()), 64'd384);
    chk("ar_seq", 64'(seq_mism(got, exp_vals)), 64'd0);

    // NUM_REGS = 1 instance
    bank1_x0 = $urandom;
    got1.delete();
    done_cyc1.delete();
    @(posedge clk); #1;
    start1 = 1'b1;
    c0 = cyc + 2;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int n = 0; n < 60 && done_cyc1.size() == 0; n++) begin
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("n1_count", 64'(got1.size()), 64'd12);
    s1 = "";
    foreach (got1[i]) s1 = $sformatf("%s%c", s1, got1[i][7:0]);
    chk_s("n1_line", s1, line_of(0, bank1_x0));
    chk("n1_done_pulses", 64'(done_cyc1.size()), 64'd1);
    if (done_cyc1.size() > 0) chk("n1_done_cycle", 64'(done_cyc1[0] - c0 + 1), 64'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
